// File: rtl/vx_mem_responder.sv
// SRAM-backed slave for the L1 memory request/response bus: byte-enabled writes, in-order tagged reads.
// Optional performance counters are built when VX_MEM_RSP_PERF_EN is defined.
module vx_mem_responder #(
    parameter int DATA_SIZE      = 64,
    parameter int ADDR_WIDTH     = 10,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [DATA_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [DATA_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready,
    output logic                   busy
`ifdef VX_MEM_RSP_PERF_EN
    ,
    output logic [31:0]            perf_reads,
    output logic [31:0]            perf_writes,
    output logic [31:0]            perf_stalls
`endif
);

    localparam int DW       = DATA_SIZE * 8;
    localparam int MEM_LINES = 1 << ADDR_WIDTH;
    localparam int CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int PTR_W    = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    logic          req_fire;
    logic          rd_acc;
    logic          wr_acc;
    logic          rsp_fire;
    logic [DW-1:0] rd_data;

    logic [DW-1:0] mem [MEM_LINES];

    always_comb begin
        req_fire = req_valid & req_ready;
        rd_acc   = req_fire & ~req_rw;
        wr_acc   = req_fire & req_rw;
        rsp_fire = rsp_valid & rsp_ready;
        rd_data  = mem[req_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                if (req_byteen[i]) mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
            end
        end
    end

    // Read pipeline: the array is read in the accept cycle; the FIFO write adds the final stage.
    logic                 enq_vld;
    logic [DW-1:0]        enq_data;
    logic [TAG_WIDTH-1:0] enq_tag;

    generate
        if (LATENCY <= 1) begin : g_no_pipe
            always_comb begin
                enq_vld  = rd_acc;
                enq_data = rd_data;
                enq_tag  = req_tag;
            end
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;

            logic                 stg_vld_q  [NSTG];
            logic                 stg_vld_d  [NSTG];
            logic [DW-1:0]        stg_data_q [NSTG];
            logic [DW-1:0]        stg_data_d [NSTG];
            logic [TAG_WIDTH-1:0] stg_tag_q  [NSTG];
            logic [TAG_WIDTH-1:0] stg_tag_d  [NSTG];

            always_comb begin
                stg_vld_d[0]  = rd_acc;
                stg_data_d[0] = rd_data;
                stg_tag_d[0]  = req_tag;
                for (int k = 1; k < NSTG; k++) begin
                    stg_vld_d[k]  = stg_vld_q[k-1];
                    stg_data_d[k] = stg_data_q[k-1];
                    stg_tag_d[k]  = stg_tag_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < NSTG; k++) stg_vld_q[k] <= 1'b0;
                end else begin
                    for (int k = 0; k < NSTG; k++) stg_vld_q[k] <= stg_vld_d[k];
                end
            end

            always_ff @(posedge clk) begin
                for (int k = 0; k < NSTG; k++) begin
                    stg_data_q[k] <= stg_data_d[k];
                    stg_tag_q[k]  <= stg_tag_d[k];
                end
            end

            always_comb begin
                enq_vld  = stg_vld_q[NSTG-1];
                enq_data = stg_data_q[NSTG-1];
                enq_tag  = stg_tag_q[NSTG-1];
            end
        end
    endgenerate

    logic [DW-1:0]        fifo_data_q [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]     pending_q, pending_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count every read between accept and response fire, so enqueue never sees a full FIFO.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (enq_vld)  wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rsp_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(enq_vld) - CNT_W'(rsp_fire);
        pending_d  = pending_q + CNT_W'(rd_acc) - CNT_W'(rsp_fire);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            pending_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            pending_q  <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_vld) begin
            fifo_data_q[wr_ptr_q] <= enq_data;
            fifo_tag_q[wr_ptr_q]  <= enq_tag;
        end
    end

    always_comb begin
        rsp_valid = (fifo_cnt_q != '0);
        rsp_data  = fifo_data_q[rd_ptr_q];
        rsp_tag   = fifo_tag_q[rd_ptr_q];
        req_ready = (pending_q < CNT_W'(RSP_FIFO_DEPTH));
        busy      = (pending_q != '0);
    end

`ifdef VX_MEM_RSP_PERF_EN
    logic [31:0] perf_reads_q, perf_reads_d;
    logic [31:0] perf_writes_q, perf_writes_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_reads_d  = perf_reads_q + 32'(rd_acc);
        perf_writes_d = perf_writes_q + 32'(wr_acc);
        perf_stalls_d = perf_stalls_q + 32'(req_valid & ~req_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    always_comb begin
        perf_reads  = perf_reads_q;
        perf_writes = perf_writes_q;
        perf_stalls = perf_stalls_q;
    end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: main instance at default sizing, second instance at DEPTH=3 for throughput.
module tb_vx_mem_responder;

    localparam int DS = 64;
    localparam int AW = 10;
    localparam int TW = 8;
    localparam int DW = DS * 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid, req_rw, req_ready, rsp_valid, rsp_ready, busy;
    logic [AW-1:0] req_addr;
    logic [DS-1:0] req_byteen;
    logic [DW-1:0] req_data, rsp_data;
    logic [TW-1:0] req_tag, rsp_tag;

    logic          b_req_valid, b_req_rw, b_req_ready, b_rsp_valid, b_rsp_ready, b_busy;
    logic [3:0]    b_req_addr;
    logic [3:0]    b_req_byteen;
    logic [31:0]   b_req_data, b_rsp_data;
    logic [TW-1:0] b_req_tag, b_rsp_tag;

`ifdef VX_MEM_RSP_PERF_EN
    logic [31:0] perf_reads, perf_writes, perf_stalls;
    logic [31:0] b_perf_reads, b_perf_writes, b_perf_stalls;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_mem_responder #(.DATA_SIZE(DS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LATENCY(2), .RSP_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready), .busy(busy)
`ifdef VX_MEM_RSP_PERF_EN
        , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
    );

    vx_mem_responder #(.DATA_SIZE(4), .ADDR_WIDTH(4), .TAG_WIDTH(TW), .LATENCY(2), .RSP_FIFO_DEPTH(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_req_valid), .req_rw(b_req_rw), .req_addr(b_req_addr),
        .req_byteen(b_req_byteen), .req_data(b_req_data), .req_tag(b_req_tag), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_tag(b_rsp_tag), .rsp_ready(b_rsp_ready), .busy(b_busy)
`ifdef VX_MEM_RSP_PERF_EN
        , .perf_reads(b_perf_reads), .perf_writes(b_perf_writes), .perf_stalls(b_perf_stalls)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string name, input int max_cyc);
        int c;
        c = 0;
        while (!rsp_valid && c < max_cyc) begin
            step();
            c++;
        end
        chk(name, DW'(rsp_valid), DW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  next_tag;
        bit  acc;
        int  got[$];
        int  drops, n_rsp, first_c, last_c, order_err, cnt;
        logic [DW-1:0] exp_data;

        req_valid = 0; req_rw = 0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0; rsp_ready = 1;
        b_req_valid = 0; b_req_rw = 0; b_req_addr = '0; b_req_byteen = '0; b_req_data = '0; b_req_tag = '0; b_rsp_ready = 1;

        // Reset values
        step(); step();
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(1));
`ifdef VX_MEM_RSP_PERF_EN
        chk("rst_perf_reads", DW'(perf_reads), DW'(0));
`endif
        reset_n = 1;
        step();

        // Full write then read, latency check
        req_valid = 1; req_rw = 1; req_addr = 10'd5; req_byteen = '1; req_data = {DS{8'hA5}};
        step();
        req_rw = 0; req_tag = 8'h03;
        step();
        req_valid = 0;
        chk("t1_not_early", DW'(rsp_valid), DW'(0));
        chk("t1_busy", DW'(busy), DW'(1));
        step();
        chk("t1_valid_at_latency", DW'(rsp_valid), DW'(1));
        chk("t1_data", rsp_data, {DS{8'hA5}});
        chk("t1_tag", DW'(rsp_tag), DW'(8'h03));
        step();
        chk("t1_drained", DW'(busy), DW'(0));

        // Partial write
        req_valid = 1; req_rw = 1; req_addr = 10'd7; req_byteen = '1; req_data = '0;
        step();
        req_byteen = DS'(1); req_data = {{(DS-1){8'h11}}, 8'hFF};
        step();
        req_rw = 0; req_tag = 8'h07;
        step();
        req_valid = 0;
        wait_rsp("t2_rsp_timeout", 10);
        exp_data = '0;
        exp_data[7:0] = 8'hFF;
        chk("t2_data", rsp_data, exp_data);
        chk("t2_tag", DW'(rsp_tag), DW'(8'h07));
        step();

        // Backpressure with DEPTH=4
        rsp_ready = 0; req_valid = 1; req_rw = 0; req_addr = 10'd5;
        next_tag = 1; req_tag = 8'd1;
        for (int c = 0; c < 8; c++) begin
            acc = req_ready;
            step();
            if (acc) begin
                next_tag++;
                req_tag = TW'(next_tag);
            end
        end
        chk("t3_accepted", DW'(next_tag - 1), DW'(4));
        chk("t3_ready_low", DW'(req_ready), DW'(0));
        chk("t3_head_tag_held", DW'(rsp_tag), DW'(1));
        chk("t3_head_data", rsp_data, {DS{8'hA5}});
`ifdef VX_MEM_RSP_PERF_EN
        chk("t3_perf_stalls", DW'(perf_stalls), DW'(4));
`endif
        rsp_ready = 1;
        for (int c = 0; c < 30 && got.size() < 6; c++) begin
            if (rsp_valid) got.push_back(int'(rsp_tag));
            acc = req_valid && req_ready;
            step();
            if (acc) begin
                next_tag++;
                if (next_tag > 6) req_valid = 0;
                else req_tag = TW'(next_tag);
            end
        end
        chk("t3_rsp_count", DW'(got.size()), DW'(6));
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_order_%0d", i), DW'((i < got.size()) ? got[i] : -1), DW'(i + 1));
        end
        step();
        chk("t3_idle", DW'(busy), DW'(0));

        // Throughput on DEPTH=3 instance
        drops = 0; n_rsp = 0; first_c = -1; last_c = -1; order_err = 0;
        for (int c = 0; c < 24; c++) begin
            b_req_valid = (c < 16);
            b_req_tag = TW'(c);
            if (c < 16 && !b_req_ready) drops++;
            if (b_rsp_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                if (int'(b_rsp_tag) != n_rsp) order_err++;
                n_rsp++;
            end
            step();
        end
        b_req_valid = 0;
        chk("t4_ready_drops", DW'(drops), DW'(0));
        chk("t4_rsp_count", DW'(n_rsp), DW'(16));
        chk("t4_first_cycle", DW'(first_c), DW'(2));
        chk("t4_last_cycle", DW'(last_c), DW'(17));
        chk("t4_order", DW'(order_err), DW'(0));

        // Reset mid-flight
        rsp_ready = 0; req_valid = 1; req_rw = 0; req_addr = 10'd5; req_tag = 8'h09;
        step(); step();
        req_valid = 0;
        chk("t5_pre_valid", DW'(rsp_valid), DW'(1));
        chk("t5_pre_busy", DW'(busy), DW'(1));
        reset_n = 0;
        #1;
        chk("t5_rst_valid", DW'(rsp_valid), DW'(0));
        chk("t5_rst_busy", DW'(busy), DW'(0));
        chk("t5_rst_ready", DW'(req_ready), DW'(1));
        step();
        reset_n = 1; rsp_ready = 1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid || busy) cnt++;
            step();
        end
        chk("t5_no_stale", DW'(cnt), DW'(0));

        // Perf counters: 3 writes, 5 reads
        req_valid = 1; req_rw = 1; req_byteen = '1;
        for (int i = 0; i < 3; i++) begin
            req_addr = AW'(20 + i); req_data = {DS{8'(i + 1)}};
            step();
        end
        req_rw = 0; req_addr = 10'd21;
        for (int i = 0; i < 5; i++) begin
            req_tag = TW'(i);
            step();
        end
        req_valid = 0;
        chk("t6_rsp_data", rsp_data, {DS{8'h02}});
        cnt = 0;
        while (busy && cnt < 20) begin
            step();
            cnt++;
        end
        chk("t6_drained", DW'(busy), DW'(0));
`ifdef VX_MEM_RSP_PERF_EN
        chk("t6_perf_writes", DW'(perf_writes), DW'(3));
        chk("t6_perf_reads", DW'(perf_reads), DW'(5));
        chk("t6_perf_stalls", DW'(perf_stalls), DW'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
